// File: rtl/fir_dec_pack_if.sv
// Sample-in / packed-word-out stream bundle for the decimating packer.
// The slave side is the packer itself; the master side feeds samples and consumes words.
interface fir_dec_pack_if #(
   parameter int DATA_WD = 16
);
   logic                 ivld;
   logic [DATA_WD-1:0]   idata;
   logic                 ordy;
   logic                 ovld;
   logic [2*DATA_WD-1:0] odata;

   modport slave (
      input  ivld,
      input  idata,
      input  ordy,
      output ovld,
      output odata
   );

   modport master (
      output ivld,
      output idata,
      output ordy,
      input  ovld,
      input  odata
   );
endinterface

// File: rtl/fir_dec_pack.sv
// Decimates the filtered sample stream by (fir_dec+1), packs kept-sample pairs into
// 32-bit words and queues them in a small first-word-fall-through FIFO with overflow count.
module fir_dec_pack #(
   parameter int DATA_WD    = 16,
   parameter int DEC_WD     = 6,
   parameter int MAX_DEC    = 39,
   parameter int FIFO_DEPTH = 8,
   parameter int CNT_WD     = 16
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          soft_rst,
   input  logic                          fir_en,
   input  logic [DEC_WD-1:0]             fir_dec,
   fir_dec_pack_if.slave                 bus,
   output logic [CNT_WD-1:0]             ovfl_cnt,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_lvl
);

   localparam int PTR_WD = $clog2(FIFO_DEPTH);
   localparam int LVL_WD = PTR_WD + 1;
   localparam logic [DEC_WD-1:0] MAX_DEC_V = DEC_WD'(MAX_DEC);
   localparam logic [LVL_WD-1:0] FULL_LVL  = LVL_WD'(FIFO_DEPTH);

   logic [DEC_WD-1:0]    ratio_q;
   logic [DEC_WD-1:0]    dec_cnt;
   logic [DEC_WD-1:0]    eff_dec;
   logic [DEC_WD-1:0]    cur_ratio;
   logic                 pack_half;
   logic [DATA_WD-1:0]   low_reg;
   logic [2*DATA_WD-1:0] mem [FIFO_DEPTH];
   logic [PTR_WD-1:0]    wr_ptr;
   logic [PTR_WD-1:0]    rd_ptr;
   logic                 keep;
   logic                 push;
   logic                 pop;
   logic                 full;
   logic                 wr_en;
   logic                 drop;

   // A group start picks up the live ratio; mid-group the latched one governs.
   always_comb begin
      eff_dec   = '0;
      if (fir_en) begin
         eff_dec = (fir_dec > MAX_DEC_V) ? MAX_DEC_V : fir_dec;
      end
      cur_ratio = (dec_cnt == '0) ? eff_dec : ratio_q;
      keep      = bus.ivld && (dec_cnt == cur_ratio);
      push      = keep && pack_half;
      pop       = (fifo_lvl != '0) && bus.ordy;
      full      = (fifo_lvl == FULL_LVL);
      wr_en     = push && (!full || pop);
      drop      = push && full && !pop;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ratio_q   <= '0;
         dec_cnt   <= '0;
         pack_half <= 1'b0;
         low_reg   <= '0;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         fifo_lvl  <= '0;
         ovfl_cnt  <= '0;
      end else if (soft_rst) begin
         ratio_q   <= '0;
         dec_cnt   <= '0;
         pack_half <= 1'b0;
         low_reg   <= '0;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         fifo_lvl  <= '0;
         ovfl_cnt  <= '0;
      end else begin
         if (bus.ivld) begin
            if (dec_cnt == '0) begin
               ratio_q <= eff_dec;
            end
            dec_cnt <= keep ? '0 : dec_cnt + 1'b1;
         end
         if (keep) begin
            pack_half <= !pack_half;
            if (!pack_half) begin
               low_reg <= bus.idata;
            end
         end
         if (wr_en) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         if (wr_en && !pop) begin
            fifo_lvl <= fifo_lvl + 1'b1;
         end else if (pop && !wr_en) begin
            fifo_lvl <= fifo_lvl - 1'b1;
         end
         if (drop && (ovfl_cnt != '1)) begin
            ovfl_cnt <= ovfl_cnt + 1'b1;
         end
      end
   end

   // Storage needs no reset: reads are masked until a word has been written.
   always_ff @(posedge clk) begin
      if (wr_en && !soft_rst) begin
         mem[wr_ptr] <= {bus.idata, low_reg};
      end
   end

   assign bus.ovld  = (fifo_lvl != '0);
   assign bus.odata = bus.ovld ? mem[rd_ptr] : '0;

endmodule

// File: tb/tb_fir_dec_pack.sv
// Randomised and directed checks of fir_dec_pack against a queue-based group/pair model.
module tb_fir_dec_pack;

   logic        clk;
   logic        rst_n;
   logic        soft_rst;
   logic        fir_en;
   logic [5:0]  fir_dec;
   logic [15:0] ovfl_cnt;
   logic [3:0]  fifo_lvl;

   fir_dec_pack_if #(.DATA_WD(16)) bus ();

   fir_dec_pack dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .soft_rst (soft_rst),
      .fir_en   (fir_en),
      .fir_dec  (fir_dec),
      .bus      (bus),
      .ovfl_cnt (ovfl_cnt),
      .fifo_lvl (fifo_lvl)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks;
   int failures;

   logic [31:0] model_q[$];
   int          m_pos;
   int          m_len;
   logic        m_half;
   logic [15:0] m_low;
   logic [15:0] m_ovfl;

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic clearModel();
      model_q.delete();
      m_pos  = 0;
      m_len  = 1;
      m_half = 1'b0;
      m_low  = '0;
      m_ovfl = '0;
   endtask

   // Compares the visible outputs with the model, then drives one cycle and advances the model.
   task automatic applyStimulus(input logic v, input logic [15:0] d, input logic r, input logic srst);
      logic        m_pop;
      logic        m_push;
      logic        m_full;
      logic [31:0] m_word;
      checkOutput("ovld", {31'b0, bus.ovld}, {31'b0, model_q.size() > 0});
      checkOutput("odata", bus.odata, (model_q.size() > 0) ? model_q[0] : 32'h0);
      checkOutput("fifo_lvl", {28'b0, fifo_lvl}, 32'(model_q.size()));
      checkOutput("ovfl_cnt", {16'b0, ovfl_cnt}, {16'b0, m_ovfl});
      bus.ivld  = v;
      bus.idata = d;
      bus.ordy  = r;
      soft_rst  = srst;
      m_word    = '0;
      if (srst) begin
         clearModel();
      end else begin
         m_pop  = (model_q.size() > 0) && r;
         m_push = 1'b0;
         if (v) begin
            if (m_pos == 0) begin
               m_len = (fir_en ? ((int'(fir_dec) > 39) ? 39 : int'(fir_dec)) : 0) + 1;
            end
            m_pos++;
            if (m_pos == m_len) begin
               m_pos = 0;
               if (m_half) begin
                  m_push = 1'b1;
                  m_word = {d, m_low};
               end else begin
                  m_low = d;
               end
               m_half = !m_half;
            end
         end
         m_full = (model_q.size() == 8);
         if (m_pop) void'(model_q.pop_front());
         if (m_push) begin
            if (!m_full || m_pop) model_q.push_back(m_word);
            else if (m_ovfl != 16'hFFFF) m_ovfl++;
         end
      end
      @(posedge clk);
      @(negedge clk);
      bus.ivld = 1'b0;
      soft_rst = 1'b0;
   endtask

   initial begin
      checks    = 0;
      failures  = 0;
      rst_n     = 1'b0;
      soft_rst  = 1'b0;
      fir_en    = 1'b0;
      fir_dec   = '0;
      bus.ivld  = 1'b0;
      bus.idata = '0;
      bus.ordy  = 1'b0;
      clearModel();
      repeat (2) @(negedge clk);
      checkOutput("rst_ovld", {31'b0, bus.ovld}, 32'h0);
      checkOutput("rst_odata", bus.odata, 32'h0);
      checkOutput("rst_lvl", {28'b0, fifo_lvl}, 32'h0);
      checkOutput("rst_ovfl", {16'b0, ovfl_cnt}, 32'h0);
      rst_n = 1'b1;
      @(negedge clk);

      // Pass-through packing and first-word latency
      applyStimulus(1'b1, 16'd1, 1'b1, 1'b0);
      applyStimulus(1'b1, 16'd2, 1'b1, 1'b0);
      checkOutput("first_ovld", {31'b0, bus.ovld}, 32'h1);
      checkOutput("word_1_2", bus.odata, 32'h00020001);
      applyStimulus(1'b1, 16'd3, 1'b1, 1'b0);
      applyStimulus(1'b1, 16'd4, 1'b1, 1'b0);
      checkOutput("word_3_4", bus.odata, 32'h00040003);
      applyStimulus(1'b0, 16'd0, 1'b1, 1'b0);

      // Decimate by 4, words held until popped
      fir_en  = 1'b1;
      fir_dec = 6'd3;
      for (int i = 0; i < 16; i++) applyStimulus(1'b1, 16'(i), 1'b0, 1'b0);
      checkOutput("dec4_lvl", {28'b0, fifo_lvl}, 32'd2);
      checkOutput("dec4_w0", bus.odata, 32'h00070003);
      applyStimulus(1'b0, 16'd0, 1'b1, 1'b0);
      checkOutput("dec4_w1", bus.odata, 32'h000F000B);
      applyStimulus(1'b0, 16'd0, 1'b1, 1'b0);

      // Clamped ratio, then a mid-group ratio change
      applyStimulus(1'b0, 16'd0, 1'b0, 1'b1);
      fir_dec = 6'd50;
      for (int i = 0; i < 10; i++) applyStimulus(1'b1, 16'(i), 1'b0, 1'b0);
      fir_dec = 6'd1;
      for (int i = 10; i < 42; i++) applyStimulus(1'b1, 16'(i), 1'b0, 1'b0);
      checkOutput("clamp_lvl", {28'b0, fifo_lvl}, 32'd1);
      checkOutput("clamp_word", bus.odata, {16'd41, 16'd39});
      for (int i = 42; i < 46; i++) applyStimulus(1'b1, 16'(i), 1'b1, 1'b0);
      checkOutput("ratio2_word", bus.odata, {16'd45, 16'd43});
      applyStimulus(1'b0, 16'd0, 1'b1, 1'b0);

      // Overflow with a stalled consumer, then push+pop while full
      applyStimulus(1'b0, 16'd0, 1'b0, 1'b1);
      fir_en = 1'b0;
      for (int i = 1; i <= 20; i++) applyStimulus(1'b1, 16'(i), 1'b0, 1'b0);
      checkOutput("full_lvl", {28'b0, fifo_lvl}, 32'd8);
      checkOutput("full_ovfl", {16'b0, ovfl_cnt}, 32'd2);
      checkOutput("full_head", bus.odata, 32'h00020001);
      applyStimulus(1'b1, 16'd21, 1'b0, 1'b0);
      applyStimulus(1'b1, 16'd22, 1'b1, 1'b0);
      checkOutput("pp_lvl", {28'b0, fifo_lvl}, 32'd8);
      checkOutput("pp_ovfl", {16'b0, ovfl_cnt}, 32'd2);
      checkOutput("pp_head", bus.odata, 32'h00040003);
      for (int i = 0; i < 9; i++) applyStimulus(1'b0, 16'd0, 1'b1, 1'b0);

      // Soft clear with a half-packed word and a non-empty FIFO
      for (int i = 1; i <= 3; i++) applyStimulus(1'b1, 16'(i), 1'b0, 1'b0);
      applyStimulus(1'b1, 16'd4, 1'b1, 1'b1);
      checkOutput("srst_ovld", {31'b0, bus.ovld}, 32'h0);
      checkOutput("srst_lvl", {28'b0, fifo_lvl}, 32'h0);
      applyStimulus(1'b1, 16'd5, 1'b0, 1'b0);
      applyStimulus(1'b1, 16'd6, 1'b0, 1'b0);
      checkOutput("srst_word", bus.odata, 32'h00060005);

      // Same clear from an asynchronous reset pulse mid-cycle
      applyStimulus(1'b1, 16'd7, 1'b0, 1'b0);
      #2 rst_n = 1'b0;
      #1;
      checkOutput("arst_ovld", {31'b0, bus.ovld}, 32'h0);
      checkOutput("arst_lvl", {28'b0, fifo_lvl}, 32'h0);
      checkOutput("arst_ovfl", {16'b0, ovfl_cnt}, 32'h0);
      clearModel();
      @(negedge clk);
      rst_n = 1'b1;
      applyStimulus(1'b1, 16'd5, 1'b0, 1'b0);
      applyStimulus(1'b1, 16'd6, 1'b0, 1'b0);
      checkOutput("arst_word", bus.odata, 32'h00060005);

      // Randomised traffic, ratio changes and occasional soft clears
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(99) < 4) begin
            fir_en  = 1'($urandom_range(1));
            fir_dec = 6'($urandom_range(63));
         end
         applyStimulus(1'($urandom_range(99) < 60), 16'($urandom),
                       1'($urandom_range(99) < 50), 1'($urandom_range(999) < 5));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
